adc_spi_responder: RTL

Synthesizable behavioural model of the 8-channel, 12-bit serial ADC that the SPI master in our oscilloscope datapath talks to. It sits on the far end of the sclk / cs_n / din / dout wires. It decodes the 3-bit channel address the master sends, and it returns a 12-bit sample for the channel addressed in the previous frame. It serves as a loopback target on the board, driven by a pattern source through `sample_data`, and as the DUT-side model in system simulation.

---
 rtl/adc_spi_responder_if.sv | 21 ++
 rtl/adc_spi_responder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/adc_spi_responder_if.sv
// rtl/adc_spi_responder_if.sv - SPI pin bundle between the scope SPI master and the ADC responder
interface adc_spi_responder_if;
  logic sclk;
  logic cs_n;
  logic din;
  logic dout;

  modport master (
    output sclk,
    output cs_n,
    output din,
    input  dout
  );

  modport slave (
    input  sclk,
    input  cs_n,
    input  din,
    output dout
  );
endinterface

// File: rtl/adc_spi_responder.sv
// rtl/adc_spi_responder.sv - behavioural 8-channel 12-bit serial ADC on the far end of the SPI wires
// Pins are oversampled by clk; the channel addressed in one frame is returned in the next.
module adc_spi_responder #(
  parameter int FRAME_BITS = 16,
  parameter int DATA_BITS  = 12,
  parameter int RESET_CH   = 0
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  adc_spi_responder_if.slave   spi,
  input  logic [DATA_BITS-1:0] i_sample_data,
  output logic [2:0]           o_cur_ch,
  output logic [2:0]           o_addr_out,
  output logic                 o_addr_strobe,
  output logic                 o_frame_done,
  output logic                 o_frame_abort
);

  localparam int CNT_W = $clog2(FRAME_BITS + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SHIFT   = 2'd1,
    S_WAIT_CS = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic r_sclk_s1, r_sclk_s2, r_sclk_s3;
  logic r_cs_s1, r_cs_s2, r_cs_s3;
  logic r_din_s1, r_din_s2;

  logic [FRAME_BITS-1:0] r_tx_sh;
  logic [1:0]            r_rx_sh;  // only the two most recent bits are needed to form the address
  logic [CNT_W-1:0]      r_bit_cnt;
  logic                  r_dout;
  logic [2:0]            r_cur_ch;
  logic [2:0]            r_addr;
  logic                  r_addr_strobe;
  logic                  r_frame_done;
  logic                  r_frame_abort;

  logic w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;
  logic w_load, w_shift_out, w_shift_in, w_done, w_abort, w_clr_dout, w_addr_hit;

  assign w_sclk_rise = r_sclk_s2 & ~r_sclk_s3;
  assign w_sclk_fall = ~r_sclk_s2 & r_sclk_s3;
  assign w_cs_rise   = r_cs_s2 & ~r_cs_s3;
  assign w_cs_fall   = ~r_cs_s2 & r_cs_s3;
  assign w_addr_hit  = w_shift_in && (r_bit_cnt == CNT_W'(4));

  // Bring the asynchronous pins into the clk domain; the third stage feeds edge detection
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sclk_s1 <= 1'b1;
      r_sclk_s2 <= 1'b1;
      r_sclk_s3 <= 1'b1;
      r_cs_s1   <= 1'b1;
      r_cs_s2   <= 1'b1;
      r_cs_s3   <= 1'b1;
      r_din_s1  <= 1'b0;
      r_din_s2  <= 1'b0;
    end else begin
      r_sclk_s1 <= spi.sclk;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_s3 <= r_sclk_s2;
      r_cs_s1   <= spi.cs_n;
      r_cs_s2   <= r_cs_s1;
      r_cs_s3   <= r_cs_s2;
      r_din_s1  <= spi.din;
      r_din_s2  <= r_din_s1;
    end
  end

  // Frame state register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and datapath controls; a cs_n rise always beats an sclk edge in the same cycle
  always_comb begin
    w_next      = r_state;
    w_load      = 1'b0;
    w_shift_out = 1'b0;
    w_shift_in  = 1'b0;
    w_done      = 1'b0;
    w_abort     = 1'b0;
    w_clr_dout  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cs_fall) begin
          w_load = 1'b1;
          w_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_cs_rise) begin
          w_abort    = 1'b1;
          w_clr_dout = 1'b1;
          w_next     = S_IDLE;
        end else if (w_sclk_fall) begin
          w_shift_out = 1'b1;
        end else if (w_sclk_rise) begin
          w_shift_in = 1'b1;
          if (r_bit_cnt == CNT_W'(FRAME_BITS - 1)) begin
            w_done = 1'b1;
            w_next = S_WAIT_CS;
          end
        end
      end
      S_WAIT_CS: begin
        if (w_cs_rise) begin
          w_clr_dout = 1'b1;
          w_next     = S_IDLE;
        end
      end
      default: begin
        w_clr_dout = 1'b1;
        w_next     = S_IDLE;
      end
    endcase
  end

  // Shift registers, bit counter, address/channel registers and status pulses
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_tx_sh       <= '0;
      r_rx_sh       <= '0;
      r_bit_cnt     <= '0;
      r_dout        <= 1'b0;
      r_cur_ch      <= 3'(RESET_CH);
      r_addr        <= 3'd0;
      r_addr_strobe <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_abort <= 1'b0;
    end else begin
      r_addr_strobe <= w_addr_hit;
      r_frame_done  <= w_done;
      r_frame_abort <= w_abort;
      if (w_load) begin
        r_tx_sh   <= FRAME_BITS'(i_sample_data);
        r_bit_cnt <= '0;
      end
      if (w_shift_out) begin
        r_dout  <= r_tx_sh[FRAME_BITS-1];
        r_tx_sh <= {r_tx_sh[FRAME_BITS-2:0], 1'b0};
      end
      if (w_shift_in) begin
        r_rx_sh   <= {r_rx_sh[0], r_din_s2};
        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      end
      if (w_addr_hit) begin
        r_addr <= {r_rx_sh, r_din_s2};
      end
      if (w_done) begin
        r_cur_ch <= r_addr;
      end
      if (w_clr_dout) begin
        r_dout <= 1'b0;
      end
    end
  end

  assign spi.dout      = r_dout;
  assign o_cur_ch      = r_cur_ch;
  assign o_addr_out    = r_addr;
  assign o_addr_strobe = r_addr_strobe;
  assign o_frame_done  = r_frame_done;
  assign o_frame_abort = r_frame_abort;

endmodule
